gardner_nco: RTL

GARDNER_NCO -- requirements
Module: gardner_nco

---
 rtl/gardner_nco.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gardner_nco.sv
// Gardner timing-recovery NCO: a down-counting phase accumulator whose underflow
// launches a pipelined restoring division giving the fractional interval mu.
module gardner_nco (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] wk,
  input  logic signed [17:0] din_i,
  input  logic signed [17:0] din_q,
  output logic signed [17:0] dout_i,
  output logic signed [17:0] dout_q,
  output logic               strobe,
  output logic [14:0]        uk
);

  localparam int N = 15;  // divider stages, one quotient bit each
  localparam int L = 16;  // launch-to-strobe latency in clocks

  logic [14:0] w;
  logic [14:0] eta_reg;
  logic [14:0] eta_next;
  logic        wrap;

  // Steps below 1/8 (including negative loop-filter outputs) are forced to 1/8.
  always_comb begin
    if (wk < 16'sh1000) begin
      w = 15'h1000;
    end else begin
      w = wk[14:0];
    end
    wrap     = (eta_reg < w);
    eta_next = eta_reg - w;  // 15-bit arithmetic gives the +2^15 wrap for free
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eta_reg <= '0;
    end else begin
      eta_reg <= eta_next;
    end
  end

  logic        valid_reg [1:N];
  logic [14:0] rem_reg   [1:N];
  logic [14:0] quo_reg   [1:N];
  logic [14:0] div_reg   [1:N];

  genvar gi;
  generate
    for (gi = 1; gi <= N; gi++) begin : g_stage
      logic        v_in;
      logic [14:0] r_in;
      logic [14:0] q_in;
      logic [14:0] d_in;
      logic [15:0] r2;
      logic        q_bit;
      logic [14:0] r_out;

      // Stage 1 takes the job straight from the phase accumulator.
      if (gi == 1) begin : g_first
        assign v_in = wrap;
        assign r_in = eta_reg;
        assign q_in = '0;
        assign d_in = w;
      end else begin : g_rest
        assign v_in = valid_reg[gi-1];
        assign r_in = rem_reg[gi-1];
        assign q_in = quo_reg[gi-1];
        assign d_in = div_reg[gi-1];
      end

      // Remainder stays below the divisor, so it always fits back into 15 bits.
      always_comb begin
        r2    = {r_in, 1'b0};
        q_bit = (r2 >= {1'b0, d_in});
        if (q_bit) begin
          r_out = 15'(r2 - {1'b0, d_in});
        end else begin
          r_out = r2[14:0];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          rem_reg[gi]   <= '0;
          quo_reg[gi]   <= '0;
          div_reg[gi]   <= '0;
        end else begin
          valid_reg[gi] <= v_in;
          rem_reg[gi]   <= r_out;
          quo_reg[gi]   <= {q_in[13:0], q_bit};
          div_reg[gi]   <= d_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe <= 1'b0;
      uk     <= '0;
    end else begin
      strobe <= valid_reg[N];
      if (valid_reg[N]) begin
        uk <= quo_reg[N];
      end
    end
  end

  // Sample delay line matched to the divider latency.
  logic signed [17:0] line_i_reg [0:L-1];
  logic signed [17:0] line_q_reg [0:L-1];

  generate
    for (gi = 0; gi < L; gi++) begin : g_line
      logic signed [17:0] tap_i;
      logic signed [17:0] tap_q;

      if (gi == 0) begin : g_head
        assign tap_i = din_i;
        assign tap_q = din_q;
      end else begin : g_tail
        assign tap_i = line_i_reg[gi-1];
        assign tap_q = line_q_reg[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          line_i_reg[gi] <= '0;
          line_q_reg[gi] <= '0;
        end else begin
          line_i_reg[gi] <= tap_i;
          line_q_reg[gi] <= tap_q;
        end
      end
    end
  endgenerate

  assign dout_i = line_i_reg[L-1];
  assign dout_q = line_q_reg[L-1];

endmodule
